// File: rtl/psum_ln_router.sv
// Psum local-network router: queues PE opsum beats and routes them to the bus,
// to the neighbouring PE, or to both, switching routes only when fully idle.
module psum_ln_router #(
    parameter int PSUM_DATA_SIZE = 8,
    parameter int PSUM_NUM       = 4,
    parameter int FIFO_DEPTH     = 4,
    localparam int W  = PSUM_NUM * PSUM_DATA_SIZE,
    localparam int PW = $clog2(FIFO_DEPTH),
    localparam int CW = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          set_info,
    input  logic [1:0]    mode_in,
    output logic [1:0]    mode,
    output logic          cfg_pending,
    output logic [W:0]    ipsum,
    input  logic          ipsum_ready,
    input  logic [W:0]    opsum,
    output logic          opsum_ready,
    input  logic [W:0]    ipsum_bus,
    output logic          ipsum_ready_bus,
    output logic [W:0]    opsum_bus,
    input  logic          opsum_ready_bus,
    output logic [CW-1:0] fifo_count
);

    // Every port pair uses valid/ready: a beat moves on a cycle where valid and
    // ready are both 1; data is don't-care while valid is 0.
    typedef enum logic [1:0] {
        MODE_BUS   = 2'd0,
        MODE_LOCAL = 2'd1,
        MODE_TEE   = 2'd2
    } mode_t;

    mode_t mode_q, mode_d, pend_q, pend_d, mode_in_dec;
    logic  cfg_pending_q, cfg_pending_d;
    logic  sent_l_q, sent_l_d, sent_b_q, sent_b_d;

    logic [W-1:0]  mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [W-1:0]  head;
    logic          empty, full, push, pop, idle;
    logic          l_valid, b_valid, l_xfer, b_xfer;

    assign empty       = (count == '0);
    assign full        = (count == CW'(FIFO_DEPTH));
    assign opsum_ready = ~full;
    assign push        = opsum[W] & opsum_ready;
    assign head        = mem[rd_ptr];
    assign fifo_count  = count;
    assign mode        = mode_q;
    assign cfg_pending = cfg_pending_q;
    assign mode_in_dec = (mode_in == 2'd3) ? MODE_BUS : mode_t'(mode_in);

    // Route selection and TEE bookkeeping
    always_comb begin
        ipsum           = ipsum_bus;
        ipsum_ready_bus = 1'b0;
        opsum_bus       = {1'b0, head};
        pop             = 1'b0;
        l_valid         = 1'b0;
        b_valid         = 1'b0;
        l_xfer          = 1'b0;
        b_xfer          = 1'b0;
        sent_l_d        = sent_l_q;
        sent_b_d        = sent_b_q;
        case (mode_q)
            MODE_LOCAL: begin
                ipsum = {~empty, head};
                pop   = ~empty & ipsum_ready;
            end
            MODE_TEE: begin
                l_valid   = ~empty & ~sent_l_q;
                b_valid   = ~empty & ~sent_b_q;
                ipsum     = {l_valid, head};
                opsum_bus = {b_valid, head};
                l_xfer    = l_valid & ipsum_ready;
                b_xfer    = b_valid & opsum_ready_bus;
                pop       = ~empty & (sent_l_q | l_xfer) & (sent_b_q | b_xfer);
                if (pop) begin
                    sent_l_d = 1'b0;
                    sent_b_d = 1'b0;
                end else begin
                    sent_l_d = sent_l_q | l_xfer;
                    sent_b_d = sent_b_q | b_xfer;
                end
            end
            default: begin
                ipsum           = ipsum_bus;
                ipsum_ready_bus = ipsum_ready;
                opsum_bus       = {~empty, head};
                pop             = ~empty & opsum_ready_bus;
            end
        endcase
    end

    // Mode FSM: a new mode lands only when no beat is queued, half-sent or arriving.
    always_comb begin
        idle          = empty & ~sent_l_q & ~sent_b_q & ~push;
        mode_d        = mode_q;
        pend_d        = pend_q;
        cfg_pending_d = cfg_pending_q;
        if (set_info) begin
            if (idle) begin
                mode_d        = mode_in_dec;
                cfg_pending_d = 1'b0;
            end else begin
                pend_d        = mode_in_dec;
                cfg_pending_d = 1'b1;
            end
        end else if (cfg_pending_q && idle) begin
            mode_d        = pend_q;
            cfg_pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            mode_q        <= MODE_BUS;
            pend_q        <= MODE_BUS;
            cfg_pending_q <= 1'b0;
            sent_l_q      <= 1'b0;
            sent_b_q      <= 1'b0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
        end else begin
            mode_q        <= mode_d;
            pend_q        <= pend_d;
            cfg_pending_q <= cfg_pending_d;
            sent_l_q      <= sent_l_d;
            sent_b_q      <= sent_b_d;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= opsum[W-1:0];
    end

endmodule

// File: tb/tb_psum_ln_router.sv
// Bench for psum_ln_router: pass-through vector table, FIFO scoreboard and
// hand-written sequences for TEE, deferred reconfiguration and mid-run reset.
module tb_psum_ln_router;

    localparam int W  = 32;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          set_info;
    logic [1:0]    mode_in;
    logic [1:0]    mode;
    logic          cfg_pending;
    logic [W:0]    ipsum;
    logic          ipsum_ready;
    logic [W:0]    opsum;
    logic          opsum_ready;
    logic [W:0]    ipsum_bus;
    logic          ipsum_ready_bus;
    logic [W:0]    opsum_bus;
    logic          opsum_ready_bus;
    logic [CW-1:0] fifo_count;

    psum_ln_router dut (
        .clk             (clk),
        .rst             (rst),
        .set_info        (set_info),
        .mode_in         (mode_in),
        .mode            (mode),
        .cfg_pending     (cfg_pending),
        .ipsum           (ipsum),
        .ipsum_ready     (ipsum_ready),
        .opsum           (opsum),
        .opsum_ready     (opsum_ready),
        .ipsum_bus       (ipsum_bus),
        .ipsum_ready_bus (ipsum_ready_bus),
        .opsum_bus       (opsum_bus),
        .opsum_ready_bus (opsum_ready_bus),
        .fifo_count      (fifo_count)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int           n_vec = 0;
    int           n_err = 0;
    logic [W-1:0] exp_q[$];
    logic [1:0]   tb_mode = 2'd0;
    logic         m_sent_l = 1'b0;
    logic         m_sent_b = 1'b0;

    task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_beat(input string name, input logic [W-1:0] act);
        if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: unexpected beat %h with empty scoreboard", name, act);
        end else begin
            check(name, {1'b0, act}, {1'b0, exp_q[0]});
        end
    endtask

    // Transfers are sampled mid-cycle; they complete on the following edge.
    always @(negedge clk) begin
        if (rst) begin
            if (tb_mode == 2'd2) begin
                if (ipsum[W] && ipsum_ready) begin
                    if (m_sent_l) check("tee_dup_local", 1, 0);
                    check_beat("tee_local_data", ipsum[W-1:0]);
                    m_sent_l = 1'b1;
                end
                if (opsum_bus[W] && opsum_ready_bus) begin
                    if (m_sent_b) check("tee_dup_bus", 1, 0);
                    check_beat("tee_bus_data", opsum_bus[W-1:0]);
                    m_sent_b = 1'b1;
                end
                if (m_sent_l && m_sent_b) begin
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                    m_sent_l = 1'b0;
                    m_sent_b = 1'b0;
                end
            end else begin
                if (opsum_bus[W] && opsum_ready_bus) begin
                    check_beat("bus_data", opsum_bus[W-1:0]);
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                end
                if (tb_mode == 2'd1 && ipsum[W] && ipsum_ready) begin
                    check_beat("local_data", ipsum[W-1:0]);
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                end
            end
            if (opsum[W] && opsum_ready) exp_q.push_back(opsum[W-1:0]);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_beat(input logic [W-1:0] d);
        opsum = {1'b1, d};
        tick();
        opsum = '0;
    endtask

    // Router must be idle: the mode then lands on the strobe edge.
    task automatic set_mode(input logic [1:0] m);
        logic [1:0] dec;
        dec = (m == 2'd3) ? 2'd0 : m;
        set_info = 1'b1;
        mode_in  = m;
        tick();
        set_info = 1'b0;
        tb_mode  = dec;
        check("set_mode_mode", {31'b0, mode}, {31'b0, dec});
        check("set_mode_pending", {32'b0, cfg_pending}, 0);
    endtask

    task automatic wait_drain(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: %0d beats still expected", exp_q.size());
        end
    endtask

    // ---------------- pass-through vector table ----------------
    typedef struct {
        logic [1:0] mode;
        logic [W:0] ibus;
        logic       rdy;
        logic [W:0] exp_ipsum;
        logic       exp_rbus;
        logic       full_cmp;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{2'd0, {1'b1, 32'hAABBCCDD}, 1'b1, {1'b1, 32'hAABBCCDD}, 1'b1, 1'b1};
        vecs[1] = '{2'd0, {1'b1, 32'hAABBCCDD}, 1'b0, {1'b1, 32'hAABBCCDD}, 1'b0, 1'b1};
        vecs[2] = '{2'd0, {1'b0, 32'h12345678}, 1'b1, {1'b0, 32'h12345678}, 1'b1, 1'b1};
        vecs[3] = '{2'd0, {1'b1, 32'hDEADBEEF}, 1'b1, {1'b1, 32'hDEADBEEF}, 1'b1, 1'b1};
        vecs[4] = '{2'd1, {1'b1, 32'hAABBCCDD}, 1'b1, {1'b0, 32'h0}, 1'b0, 1'b0};
        vecs[5] = '{2'd1, {1'b1, 32'h55AA55AA}, 1'b0, {1'b0, 32'h0}, 1'b0, 1'b0};
        vecs[6] = '{2'd2, {1'b1, 32'hAABBCCDD}, 1'b1, {1'b0, 32'h0}, 1'b0, 1'b0};
        vecs[7] = '{2'd0, {1'b1, 32'h0F0F0F0F}, 1'b1, {1'b1, 32'h0F0F0F0F}, 1'b1, 1'b1};
    end

    // ---------------- main sequence ----------------
    initial begin
        rst = 1'b0; set_info = 1'b0; mode_in = 2'd0;
        ipsum_ready = 1'b0; opsum = '0; ipsum_bus = {1'b1, 32'h01234567};
        opsum_ready_bus = 1'b0;
        tick();
        tick();
        rst = 1'b1;

        // Reset state
        check("rst_mode", {31'b0, mode}, 0);
        check("rst_pending", {32'b0, cfg_pending}, 0);
        check("rst_count", {30'b0, fifo_count}, 0);
        check("rst_opsum_ready", {32'b0, opsum_ready}, 1);
        check("rst_opsum_bus_valid", {32'b0, opsum_bus[W]}, 0);
        check("rst_ipsum_pass", ipsum, {1'b1, 32'h01234567});

        // Table: combinational ipsum path in each mode (FIFO empty)
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].mode != tb_mode) set_mode(vecs[i].mode);
            ipsum_bus   = vecs[i].ibus;
            ipsum_ready = vecs[i].rdy;
            #1;
            if (vecs[i].full_cmp) check($sformatf("vec%0d_ipsum", i), ipsum, vecs[i].exp_ipsum);
            else check($sformatf("vec%0d_ipsum_valid", i), {32'b0, ipsum[W]}, {32'b0, vecs[i].exp_ipsum[W]});
            check($sformatf("vec%0d_ready_bus", i), {32'b0, ipsum_ready_bus}, {32'b0, vecs[i].exp_rbus});
            tick();
        end
        ipsum_bus = '0; ipsum_ready = 1'b0;

        // BUS: fill to full under back-pressure, then drain in order
        opsum_ready_bus = 1'b0;
        for (int i = 0; i < 4; i++) begin
            logic [W-1:0] d;
            d = 32'h01020304 + 32'h01010101 * i;
            push_beat(d);
            check($sformatf("fill_count%0d", i), {30'b0, fifo_count}, i + 1);
        end
        check("full_opsum_ready", {32'b0, opsum_ready}, 0);
        opsum_ready_bus = 1'b1;
        for (int i = 0; i < 4; i++) begin
            logic [W-1:0] d;
            d = 32'h01020304 + 32'h01010101 * i;
            check($sformatf("drain_beat%0d", i), opsum_bus, {1'b1, d});
            tick();
        end
        check("drain_empty", {30'b0, fifo_count}, 0);
        check("drain_valid_low", {32'b0, opsum_bus[W]}, 0);

        // BUS: random streaming
        for (int i = 0; i < 40; i++) begin
            opsum = {1'($urandom_range(0, 1)), 32'($urandom)};
            opsum_ready_bus = ($urandom_range(0, 3) != 0);
            tick();
        end
        opsum = '0; opsum_ready_bus = 1'b1;
        wait_drain(20);
        check("bus_rand_empty", {30'b0, fifo_count}, 0);
        opsum_ready_bus = 1'b0;

        // LOCAL
        set_mode(2'd1);
        push_beat(32'h11111111);
        check("local_ipsum", ipsum, {1'b1, 32'h11111111});
        check("local_bus_quiet0", {32'b0, opsum_bus[W]}, 0);
        ipsum_ready = 1'b1;
        opsum_ready_bus = 1'b1;
        #1;
        check("local_bus_quiet1", {32'b0, opsum_bus[W]}, 0);
        tick();
        check("local_popped", {30'b0, fifo_count}, 0);
        check("local_valid_low", {32'b0, ipsum[W]}, 0);
        ipsum_ready = 1'b0; opsum_ready_bus = 1'b0;

        // TEE: local side first, bus later
        set_mode(2'd2);
        ipsum_ready = 1'b1;
        push_beat(32'h22222222);
        check("tee_local_offer", ipsum, {1'b1, 32'h22222222});
        tick();
        check("tee_local_done", {32'b0, ipsum[W]}, 0);
        check("tee_count_held", {30'b0, fifo_count}, 1);
        tick();
        check("tee_local_still_low", {32'b0, ipsum[W]}, 0);
        check("tee_bus_offer", opsum_bus, {1'b1, 32'h22222222});
        opsum_ready_bus = 1'b1;
        tick();
        check("tee_popped", {30'b0, fifo_count}, 0);
        check("tee_bus_low", {32'b0, opsum_bus[W]}, 0);

        // TEE: random streaming
        for (int i = 0; i < 40; i++) begin
            opsum = {1'($urandom_range(0, 1)), 32'($urandom)};
            ipsum_ready = ($urandom_range(0, 2) != 0);
            opsum_ready_bus = ($urandom_range(0, 2) != 0);
            tick();
        end
        opsum = '0; ipsum_ready = 1'b1; opsum_ready_bus = 1'b1;
        wait_drain(30);
        check("tee_rand_empty", {30'b0, fifo_count}, 0);
        ipsum_ready = 1'b0; opsum_ready_bus = 1'b0;

        // Reserved mode code decodes as BUS
        set_mode(2'd3);

        // Deferred config with last-write-wins
        push_beat(32'hA1A1A1A1);
        push_beat(32'hA2A2A2A2);
        set_info = 1'b1; mode_in = 2'd2;
        tick();
        mode_in = 2'd1;
        tick();
        set_info = 1'b0;
        check("defer_pending", {32'b0, cfg_pending}, 1);
        check("defer_mode_held", {31'b0, mode}, 0);
        opsum_ready_bus = 1'b1;
        tick();
        check("defer_mode_held1", {31'b0, mode}, 0);
        check("defer_pending1", {32'b0, cfg_pending}, 1);
        tick();
        check("defer_drained", {30'b0, fifo_count}, 0);
        check("defer_mode_held2", {31'b0, mode}, 0);
        tick();
        tb_mode = 2'd1;
        check("defer_applied", {31'b0, mode}, 1);
        check("defer_cleared", {32'b0, cfg_pending}, 0);
        opsum_ready_bus = 1'b0;

        // Reset mid-operation
        set_mode(2'd0);
        push_beat(32'hB1B1B1B1);
        push_beat(32'hB2B2B2B2);
        push_beat(32'hB3B3B3B3);
        set_info = 1'b1; mode_in = 2'd2;
        tick();
        set_info = 1'b0;
        check("mid_pending", {32'b0, cfg_pending}, 1);
        rst = 1'b0;
        exp_q.delete();
        m_sent_l = 1'b0; m_sent_b = 1'b0;
        tick();
        rst = 1'b1;
        check("mid_count", {30'b0, fifo_count}, 0);
        check("mid_mode", {31'b0, mode}, 0);
        check("mid_pending_clr", {32'b0, cfg_pending}, 0);
        opsum_ready_bus = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("mid_no_stale%0d", i), {32'b0, opsum_bus[W]}, 0);
            tick();
        end
        check("mid_still_bus", {31'b0, mode}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
